// File: rtl/bip_pkg.sv
// Shared definitions for the multi-cycle BIP core: opcodes, FSM states, immediate sign-extension.
package bip_pkg;

  localparam int unsigned OP_HLT  = 0;
  localparam int unsigned OP_STO  = 1;
  localparam int unsigned OP_LD   = 2;
  localparam int unsigned OP_LDI  = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_ADDI = 5;
  localparam int unsigned OP_SUB  = 6;
  localparam int unsigned OP_SUBI = 7;
  localparam int unsigned OP_BEQ  = 8;
  localparam int unsigned OP_BNE  = 9;
  localparam int unsigned OP_JMP  = 10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Sign-extend the low w bits of v to 64 bits; callers truncate to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = {64{1'b1}} << w;
    return v[6'(w - 1)] ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/bip_alu.sv
// Combinational add/subtract unit for the BIP accumulator, modulo 2^DATA_W.
module bip_alu #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/bip_core_mc.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALT FSM with PC, IR, ACC,
// ready-handshaked data port and a saturating cycle counter.
module bip_core_mc
  import bip_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned OPND_W = DATA_W - OP_W,
  parameter int unsigned PC_W   = 11,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic [PC_W-1:0]   o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [OPND_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  input  logic [DATA_W-1:0] i_ram_data,
  input  logic              i_ram_ready,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_cycles
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                halted_q, halted_d;

  logic [OP_W-1:0]     opc;
  logic [OPND_W-1:0]   opnd;
  logic [DATA_W-1:0]   imm;
  logic [PC_W-1:0]     br_tgt;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_sub;

  assign opc     = ir_q[DATA_W-1 -: OP_W];
  assign opnd    = ir_q[OPND_W-1:0];
  assign imm     = DATA_W'(sext(64'(opnd), OPND_W));
  assign br_tgt  = PC_W'(opnd);
  assign alu_sub = (opc == OP_W'(OP_SUB)) || (opc == OP_W'(OP_SUBI));
  assign alu_b   = (state_q == ST_MEM) ? i_ram_data : imm;

  bip_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i   (acc_q),
    .b_i   (alu_b),
    .sub_i (alu_sub),
    .y_o   (alu_y)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    halted_d = halted_q;
    cyc_d    = cyc_q;
    if (state_q != ST_HALT && cyc_q != '1) cyc_d = cyc_q + 1'b1;
    case (state_q)
      ST_FETCH: begin
        ir_d    = i_rom_data;
        pc_d    = pc_q + 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opc)
          OP_W'(OP_HLT): begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          OP_W'(OP_STO): begin
            wr_d    = 1'b1;
            state_d = ST_MEM;
          end
          OP_W'(OP_LD), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
            rd_d    = 1'b1;
            state_d = ST_MEM;
          end
          OP_W'(OP_LDI):                  acc_d = imm;
          OP_W'(OP_ADDI), OP_W'(OP_SUBI): acc_d = alu_y;
          OP_W'(OP_BEQ): if (acc_q == '0) pc_d = br_tgt;
          OP_W'(OP_BNE): if (acc_q != '0) pc_d = br_tgt;
          OP_W'(OP_JMP):                  pc_d = br_tgt;
          default: ;
        endcase
      end
      ST_MEM: begin
        // Strobes are registered, so they fall on the same edge that completes the access.
        if (i_ram_ready) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_FETCH;
          if (opc == OP_W'(OP_LD)) acc_d = i_ram_data;
          else if (opc != OP_W'(OP_STO)) acc_d = alu_y;
        end
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      cyc_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      cyc_q    <= cyc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      halted_q <= halted_d;
    end
  end

  assign o_rom_addr  = pc_q;
  assign o_ram_addr  = opnd;
  assign o_ram_wdata = acc_q;
  assign o_ram_wr    = wr_q;
  assign o_ram_rd    = rd_q;
  assign o_acc       = acc_q;
  assign o_halted    = halted_q;
  assign o_cycles    = cyc_q;

endmodule

// File: tb/tb_bip_core_mc.sv
// Directed bench for bip_core_mc with a scoreboard of expected data-memory accesses.
module tb_bip_core_mc;

  localparam int NOP_OP = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;

  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wr, ram_rd;
  logic [15:0] ram_data;
  logic        ready;
  logic [15:0] acc;
  logic        halted;
  logic [31:0] cycles;

  logic [2:0]  rom_addr2;
  logic [15:0] rom_data2;
  logic [10:0] ram_addr2;
  logic [15:0] ram_wdata2;
  logic        ram_wr2, ram_rd2;
  logic [15:0] acc2;
  logic        halted2;
  logic [31:0] cycles2;

  logic [15:0] rom  [0:2047];
  logic [15:0] ram  [0:2047];
  logic [15:0] rom2 [0:7];

  int lat = 1;
  logic stall = 1'b0;
  int wcnt = 0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit is_wr;
    int addr;
    int data;
    int len;
    int acc;
  } acc_t;
  acc_t sb[$];

  int  slen = 0;
  bit  pend = 1'b0;
  int  pend_acc = 0;
  int  addr3_cnt = 0;

  always #5 clk = ~clk;

  assign rom_data  = rom[rom_addr];
  assign ram_data  = ram[ram_addr];
  assign ready     = (ram_rd || ram_wr) && !stall && (wcnt == lat - 1);
  assign rom_data2 = rom2[rom_addr2];

  bip_core_mc #(.DATA_W(16), .OP_W(5), .PC_W(11), .CNT_W(32)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .o_ram_wr(ram_wr), .o_ram_rd(ram_rd),
    .i_ram_data(ram_data), .i_ram_ready(ready),
    .o_acc(acc), .o_halted(halted), .o_cycles(cycles)
  );

  bip_core_mc #(.DATA_W(16), .OP_W(5), .PC_W(3), .CNT_W(32)) dut_wrap (
    .i_clock(clk), .i_reset(rst2_n),
    .o_rom_addr(rom_addr2), .i_rom_data(rom_data2),
    .o_ram_addr(ram_addr2), .o_ram_wdata(ram_wdata2),
    .o_ram_wr(ram_wr2), .o_ram_rd(ram_rd2),
    .i_ram_data(16'h0000), .i_ram_ready(1'b1),
    .o_acc(acc2), .o_halted(halted2), .o_cycles(cycles2)
  );

  function automatic logic [15:0] ins(input int op, input int opnd);
    return {op[4:0], opnd[10:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model: wait-state counter and write port
  always @(posedge clk) begin
    if ((ram_rd || ram_wr) && !ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (ram_wr && ready) ram[ram_addr] <= ram_wdata;
  end

  // Access monitor: pops the scoreboard on each completing access
  always @(negedge clk) begin
    if (!rst_n) begin
      slen = 0;
      pend = 1'b0;
      addr3_cnt = 0;
    end else begin
      if (rom_addr == 11'd3) addr3_cnt++;
      if (pend) begin
        chk("read_acc", 64'(acc), 64'(pend_acc));
        pend = 1'b0;
      end
      if (ram_rd || ram_wr) begin
        chk("no_rd_wr_overlap", 64'(ram_rd && ram_wr), 64'd0);
        slen++;
        if (ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_access", 64'd1, 64'd0);
          end else begin
            acc_t e;
            e = sb.pop_front();
            chk("acc_kind_wr", 64'(ram_wr), 64'(e.is_wr));
            chk("acc_addr", 64'(ram_addr), 64'(e.addr));
            chk("strobe_len", 64'(slen), 64'(e.len));
            if (e.is_wr) chk("wr_data", 64'(ram_wdata), 64'(e.data));
            else begin
              pend = 1'b1;
              pend_acc = e.acc;
            end
          end
          slen = 0;
        end
      end else begin
        slen = 0;
      end
    end
  end

  task automatic reset_and_clear(input int lat_v);
    rst_n = 1'b0;
    stall = 1'b0;
    lat = lat_v;
    for (int i = 0; i < 2048; i++) begin
      rom[i] = ins(NOP_OP, 0);
      ram[i] = 16'h0000;
    end
  endtask

  task automatic release_and_run(input string tag, input int budget);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk({tag, "_halted"}, 64'(halted), 64'd1);
  endtask

  function automatic acc_t mk(input bit w, input int a, input int d, input int l, input int ac);
    acc_t e;
    e.is_wr = w; e.addr = a; e.data = d; e.len = l; e.acc = ac;
    return e;
  endfunction

  initial begin
    // Test 1: reset values, then LDI 5; ADDI -2; HLT
    reset_and_clear(1);
    rom[0] = ins(3, 5);
    rom[1] = ins(5, 11'h7FE);
    rom[2] = ins(0, 0);
    @(negedge clk);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_pc", 64'(rom_addr), 64'd0);
    chk("rst_strobes", 64'({ram_rd, ram_wr}), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_wdata", 64'(ram_wdata), 64'd0);
    release_and_run("t1", 20);
    chk("t1_acc", 64'(acc), 64'd3);
    chk("t1_cycles", 64'(cycles), 64'd6);
    repeat (4) @(negedge clk);
    chk("t1_cycles_frozen", 64'(cycles), 64'd6);
    chk("t1_halt_strobes", 64'({ram_rd, ram_wr}), 64'd0);

    // Test 2: store/load round trip with 3 MEM cycles per access
    reset_and_clear(3);
    rom[0] = ins(3, 7);
    rom[1] = ins(1, 11'h010);
    rom[2] = ins(3, 0);
    rom[3] = ins(2, 11'h010);
    rom[4] = ins(0, 0);
    sb.push_back(mk(1'b1, 11'h010, 7, 3, 0));
    sb.push_back(mk(1'b0, 11'h010, 0, 3, 7));
    release_and_run("t2", 60);
    chk("t2_acc", 64'(acc), 64'd7);
    chk("t2_ram", 64'(ram[16]), 64'd7);
    chk("t2_cycles", 64'(cycles), 64'd16);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Test 3: taken BEQ skips address 3 (seen only as PC during BEQ's EXEC)
    reset_and_clear(1);
    rom[0] = ins(3, 1);
    rom[1] = ins(7, 1);
    rom[2] = ins(8, 5);
    rom[3] = ins(3, 9);
    rom[4] = ins(0, 0);
    rom[5] = ins(3, 4);
    rom[6] = ins(0, 0);
    release_and_run("t3", 40);
    chk("t3_acc", 64'(acc), 64'd4);
    chk("t3_addr3_cycles", 64'(addr3_cnt), 64'd1);
    chk("t3_cycles", 64'(cycles), 64'd10);

    // Test 4: memory ADD/SUB, negative result, taken BNE
    reset_and_clear(2);
    rom[0] = ins(3, 10);
    rom[1] = ins(1, 11'h020);
    rom[2] = ins(3, 3);
    rom[3] = ins(4, 11'h020);
    rom[4] = ins(6, 11'h020);
    rom[5] = ins(7, 5);
    rom[6] = ins(9, 8);
    rom[7] = ins(3, 0);
    rom[8] = ins(0, 0);
    sb.push_back(mk(1'b1, 11'h020, 10, 2, 0));
    sb.push_back(mk(1'b0, 11'h020, 0, 2, 13));
    sb.push_back(mk(1'b0, 11'h020, 0, 2, 3));
    release_and_run("t4", 60);
    chk("t4_acc", 64'(acc), 64'hFFFE);
    chk("t4_cycles", 64'(cycles), 64'd22);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Test 5: modulo wrap of the accumulator
    reset_and_clear(1);
    rom[0] = ins(7, 1);
    rom[1] = ins(0, 0);
    release_and_run("t5a", 20);
    chk("t5_subi_wrap", 64'(acc), 64'hFFFF);
    reset_and_clear(1);
    rom[0] = ins(7, 1);
    rom[1] = ins(5, 1);
    rom[2] = ins(0, 0);
    release_and_run("t5b", 20);
    chk("t5_addi_wrap", 64'(acc), 64'h0000);

    // Test 6: reset mid-MEM of a stalled STO, then restart from address 0
    reset_and_clear(1);
    rom[0] = ins(3, 7);
    rom[1] = ins(1, 11'h010);
    rom[2] = ins(0, 0);
    stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_wr) break;
    end
    chk("t6_wr_seen", 64'(ram_wr), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wr_drop", 64'(ram_wr), 64'd0);
    chk("t6_acc", 64'(acc), 64'd0);
    chk("t6_pc", 64'(rom_addr), 64'd0);
    chk("t6_cycles", 64'(cycles), 64'd0);
    chk("t6_ram_untouched", 64'(ram[16]), 64'd0);
    @(negedge clk);
    stall = 1'b0;
    sb.push_back(mk(1'b1, 11'h010, 7, 1, 0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart_pc", 64'(rom_addr), 64'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk("t6_halted", 64'(halted), 64'd1);
    chk("t6_final_acc", 64'(acc), 64'd7);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Test 7: PC wrap on a 3-bit PC; HLT appears at address 1 only after the first pass
    for (int i = 0; i < 8; i++) rom2[i] = ins(NOP_OP, 0);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rom_addr2 == 3'd4) rom2[1] = ins(0, 0);
      if (halted2) break;
    end
    chk("t7_halted", 64'(halted2), 64'd1);
    chk("t7_cycles", 64'(cycles2), 64'd20);
    chk("t7_pc", 64'(rom_addr2), 64'd2);
    chk("t7_no_mem", 64'({ram_rd2, ram_wr2}), 64'd0);
    chk("t7_ram_addr", 64'(ram_addr2), 64'd0);
    chk("t7_wdata", 64'(ram_wdata2), 64'd0);
    chk("t7_acc", 64'(acc2), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
